dco_code_monitor: RTL and testbench
===================================

DCO_CODE_MONITOR -- requirements
Module: dco_code_monitor

Interface
REQ-001 SHALL have parameter NUM_DCO_MATRIX_ROWS, default 17, DCO matrix rows (row select width = value-1).
REQ-002 SHALL have parameter NUM_DCO_MATRIX_COLUMNS, default 15, DCO matrix columns (column select width = value-1).
REQ-003 SHALL have parameter NUM_DCO_CONTROL_BITS_INT, default 8, decoded code width.
REQ-004 SHALL have parameter NUM_WINDOW_BITS, default 10, log2 of the maximum observation window.
REQ-005 SHALL have one clock and an asynchronous active-low reset: referenceClock (input, 1, sole clock) and resetB (input, 1, async active-low reset).
REQ-006 SHALL have ports:
- monitorEnable  input  1  run observation windows
- windowSel  input  4  window length = 2^windowSel samples
- dcoRowSelect  input  ROWS-1  active-low row thermometer driven to the DCO
- dcoColumnSelect  input  COLS-1  active-low column thermometer
- dcoDither  input  1  DCO dither bit
- currentCode  output  INT  last valid decoded code
- currentCodeValid  output  1  sample decoded legally
- reportValid  output  1  window report held
- reportReady  input  1  consumer accepts report
- reportMinCode  output  INT  window minimum
- reportMaxCode  output  INT  window maximum
- reportDitherCount  output  NUM_WINDOW_BITS+1  dither ones in window
- reportInvalidCount  output  NUM_WINDOW_BITS+1  illegal samples in window
- overrun  output  1  sticky; a report was dropped

Function
REQ-007 SHALL decode each cycle: rowsOn = zero bits in dcoRowSelect, colsOn = zero bits in dcoColumnSelect, code = rowsOn*NUM_DCO_MATRIX_COLUMNS + colsOn (default range 0..254).
REQ-008 SHALL treat a sample as legal only when each select is contiguous zeros from LSB then ones (for example 16'hFFF0 legal, 16'hFFF5 illegal).
REQ-009 SHALL register currentCode and currentCodeValid one cycle after sampling; an illegal sample clears currentCodeValid and holds currentCode.
REQ-010 SHALL implement FSM IDLE/OBSERVE: IDLE->OBSERVE when monitorEnable=1; OBSERVE->IDLE when monitorEnable=0 (window aborted, accumulators cleared, no report).
REQ-011 SHALL latch windowSel at window start, clamping values above NUM_WINDOW_BITS to NUM_WINDOW_BITS.
REQ-012 SHALL accumulate over exactly 2^windowSel samples: min/max of legal codes, count of dcoDither=1, count of illegal samples; windows run back-to-back without gap cycles.
REQ-013 SHALL report min=all-ones and max=0 when a window has no legal sample.
REQ-014 SHALL load the report and assert reportValid the cycle after the last window sample; reportValid clears on reportValid&&reportReady.
REQ-015 SHALL, at window end with reportValid=1 and reportReady=0, discard the new report, keep the old report, and set overrun.
REQ-016 SHALL, at window end coinciding with acceptance, load the new report with reportValid held at 1.
REQ-017 SHALL keep a pending report across monitorEnable=0 until it is accepted; overrun clears only while monitorEnable=0.

Reset
REQ-018 SHALL, on resetB low, asynchronously force IDLE, currentCode=0, currentCodeValid=0, reportValid=0, all report fields 0, overrun=0, and accumulators cleared.

Configuration
REQ-019 SHALL include the dither counter only when DCO_MON_DITHER_COUNT_EN is defined; without it, reportDitherCount SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-020 SHALL place the FSM state typedef and the window-clamp constant in shared package bbpll_pkg.
REQ-021 SHALL implement the thermometer-to-count decode with legality flag as sub-module dco_therm_decode, instantiated once per select bus.

Verification
REQ-022 SHALL cover: row=16'hFFF0 and col=14'h3FF8 held, windowSel=4 -> currentCode=63 after 1 cycle; report min=max=63, invalidCount=0 after 16 samples.
REQ-023 SHALL cover: row=16'h0000 and col=14'h0000 -> code 254; row=16'hFFFF and col=14'h3FFF -> code 0; alternating the two over a 4-sample window -> min=0, max=254.
REQ-024 SHALL cover: row=16'hFFF5 injected for 3 of 16 samples -> invalidCount=3, currentCodeValid=0 on those cycles, min/max from legal samples only.
REQ-025 SHALL cover: reportReady=0 across two window ends -> first report retained and overrun=1; overrun clears after monitorEnable=0.
REQ-026 SHALL cover: dcoDither toggled every cycle, windowSel=3 -> reportDitherCount=4 (0 without DCO_MON_DITHER_COUNT_EN).
REQ-027 SHALL cover: resetB asserted mid-window -> all outputs 0 immediately, and the first report after release reflects only post-reset samples.

Source files
------------

// File: rtl/bbpll_pkg.sv
// Shared types and constants for the BBPLL DCO code monitor.
// Holds the monitor FSM state type and the observation-window clamp.
package bbpll_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_OBSERVE = 1'b1
  } mon_state_e;

  localparam int unsigned WIN_SEL_W    = 4;
  localparam int unsigned WIN_BITS_MAX = 10;

  // Limit a requested window exponent to what the sample counter can hold.
  function automatic logic [WIN_SEL_W-1:0] clamp_window_sel(
    input logic [WIN_SEL_W-1:0] sel,
    input int unsigned          max_bits
  );
    if (32'(sel) > max_bits) begin
      return WIN_SEL_W'(max_bits);
    end
    return sel;
  endfunction

endpackage : bbpll_pkg

// File: rtl/dco_code_monitor_if.sv
// Control, DCO-select and window-report signals of the DCO code monitor.
// The master side drives selects and accepts reports; the slave is the monitor.
interface dco_code_monitor_if #(
  parameter int unsigned NUM_DCO_MATRIX_ROWS      = 17,
  parameter int unsigned NUM_DCO_MATRIX_COLUMNS   = 15,
  parameter int unsigned NUM_DCO_CONTROL_BITS_INT = 8,
  parameter int unsigned NUM_WINDOW_BITS          = bbpll_pkg::WIN_BITS_MAX
);

  logic                                  monitorEnable;
  logic [bbpll_pkg::WIN_SEL_W-1:0]       windowSel;
  logic [NUM_DCO_MATRIX_ROWS-2:0]        dcoRowSelect;
  logic [NUM_DCO_MATRIX_COLUMNS-2:0]     dcoColumnSelect;
  logic                                  dcoDither;
  logic [NUM_DCO_CONTROL_BITS_INT-1:0]   currentCode;
  logic                                  currentCodeValid;
  logic                                  reportValid;
  logic                                  reportReady;
  logic [NUM_DCO_CONTROL_BITS_INT-1:0]   reportMinCode;
  logic [NUM_DCO_CONTROL_BITS_INT-1:0]   reportMaxCode;
  logic [NUM_WINDOW_BITS:0]              reportDitherCount;
  logic [NUM_WINDOW_BITS:0]              reportInvalidCount;
  logic                                  overrun;

  modport master (
    output monitorEnable, windowSel, dcoRowSelect, dcoColumnSelect, dcoDither,
    output reportReady,
    input  currentCode, currentCodeValid, reportValid, reportMinCode,
    input  reportMaxCode, reportDitherCount, reportInvalidCount, overrun
  );

  modport slave (
    input  monitorEnable, windowSel, dcoRowSelect, dcoColumnSelect, dcoDither,
    input  reportReady,
    output currentCode, currentCodeValid, reportValid, reportMinCode,
    output reportMaxCode, reportDitherCount, reportInvalidCount, overrun
  );

endinterface : dco_code_monitor_if

// File: rtl/dco_therm_decode.sv
// Active-low thermometer decode: counts zero bits and flags whether the
// zeros form one contiguous run starting at the LSB.
module dco_therm_decode #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_sel,
  output logic [CNT_W-1:0] o_count_c,
  output logic             o_legal_c
);

  always_comb begin
    o_count_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!i_sel[i]) begin
        o_count_c = o_count_c + CNT_W'(1);
      end
    end
  end

  // A zero sitting above a one breaks the thermometer.
  always_comb begin
    o_legal_c = 1'b1;
    for (int unsigned i = 1; i < W; i++) begin
      if (i_sel[i-1] && !i_sel[i]) begin
        o_legal_c = 1'b0;
      end
    end
  end

endmodule : dco_therm_decode

// File: rtl/dco_code_monitor.sv
// Decodes the DCO row/column thermometer selects each cycle and reports
// min/max/invalid statistics over power-of-two windows.
// Optional dither counting is enabled with `define DCO_MON_DITHER_COUNT_EN.
module dco_code_monitor
  import bbpll_pkg::*;
#(
  parameter int unsigned NUM_DCO_MATRIX_ROWS      = 17,
  parameter int unsigned NUM_DCO_MATRIX_COLUMNS   = 15,
  parameter int unsigned NUM_DCO_CONTROL_BITS_INT = 8,
  parameter int unsigned NUM_WINDOW_BITS          = WIN_BITS_MAX
) (
  input logic               referenceClock,
  input logic               resetB,
  dco_code_monitor_if.slave mon
);

  localparam int unsigned ROW_W     = NUM_DCO_MATRIX_ROWS - 1;
  localparam int unsigned COL_W     = NUM_DCO_MATRIX_COLUMNS - 1;
  localparam int unsigned ROW_CNT_W = $clog2(NUM_DCO_MATRIX_ROWS);
  localparam int unsigned COL_CNT_W = $clog2(NUM_DCO_MATRIX_COLUMNS);
  localparam int unsigned CODE_W    = NUM_DCO_CONTROL_BITS_INT;
  localparam int unsigned CNT_W     = NUM_WINDOW_BITS + 1;

  logic [ROW_CNT_W-1:0]  w_rows_on;
  logic [COL_CNT_W-1:0]  w_cols_on;
  logic                  w_row_legal;
  logic                  w_col_legal;
  logic                  w_legal;
  logic [CODE_W-1:0]     w_code;

  mon_state_e            r_state;
  mon_state_e            w_state_next;
  logic                  w_start;
  logic                  w_sample;
  logic                  w_abort;
  logic                  w_last;
  logic                  w_win_end;
  logic                  w_rep_load;
  logic [WIN_SEL_W-1:0]  w_win_sel_clamped;
  logic [CNT_W-1:0]      w_win_len_m1;

  logic [CODE_W-1:0]     r_code;
  logic                  r_code_valid;
  logic [WIN_SEL_W-1:0]  r_win_sel;
  logic [CNT_W-1:0]      r_sample_cnt;
  logic [CODE_W-1:0]     r_min;
  logic [CODE_W-1:0]     r_max;
  logic [CNT_W-1:0]      r_inv_cnt;
  logic [CODE_W-1:0]     w_min_next;
  logic [CODE_W-1:0]     w_max_next;
  logic [CNT_W-1:0]      w_inv_next;

  logic                  r_rep_valid;
  logic [CODE_W-1:0]     r_rep_min;
  logic [CODE_W-1:0]     r_rep_max;
  logic [CNT_W-1:0]      r_rep_inv;
  logic                  r_overrun;

  dco_therm_decode #(
    .W     (ROW_W),
    .CNT_W (ROW_CNT_W)
  ) u_row_decode (
    .i_sel     (mon.dcoRowSelect),
    .o_count_c (w_rows_on),
    .o_legal_c (w_row_legal)
  );

  dco_therm_decode #(
    .W     (COL_W),
    .CNT_W (COL_CNT_W)
  ) u_col_decode (
    .i_sel     (mon.dcoColumnSelect),
    .o_count_c (w_cols_on),
    .o_legal_c (w_col_legal)
  );

  assign w_legal = w_row_legal & w_col_legal;
  assign w_code  = CODE_W'(32'(w_rows_on) * NUM_DCO_MATRIX_COLUMNS + 32'(w_cols_on));

  // Last decoded legal code; an illegal sample only drops the valid flag.
  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= w_legal;
      if (w_legal) begin
        r_code <= w_code;
      end
    end
  end

  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mon.monitorEnable) begin
          w_state_next = ST_OBSERVE;
          w_start      = 1'b1;
        end
      end
      ST_OBSERVE: begin
        if (mon.monitorEnable) begin
          w_sample = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_abort      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_win_sel_clamped = clamp_window_sel(mon.windowSel, NUM_WINDOW_BITS);
  assign w_win_len_m1      = CNT_W'((32'd1 << r_win_sel) - 32'd1);
  assign w_last            = (r_sample_cnt == w_win_len_m1);
  assign w_win_end         = w_sample & w_last;
  assign w_rep_load        = w_win_end & (~r_rep_valid | mon.reportReady);

  // Accumulator values including the sample on the current cycle.
  always_comb begin
    w_min_next = r_min;
    w_max_next = r_max;
    w_inv_next = r_inv_cnt;
    if (w_legal) begin
      if (w_code < r_min) begin
        w_min_next = w_code;
      end
      if (w_code > r_max) begin
        w_max_next = w_code;
      end
    end else begin
      w_inv_next = r_inv_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_win_sel    <= '0;
      r_sample_cnt <= '0;
      r_min        <= '1;
      r_max        <= '0;
      r_inv_cnt    <= '0;
    end else if (w_start || w_abort || w_win_end) begin
      r_sample_cnt <= '0;
      r_min        <= '1;
      r_max        <= '0;
      r_inv_cnt    <= '0;
      if (!w_abort) begin
        r_win_sel <= w_win_sel_clamped;
      end
    end else if (w_sample) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      r_min        <= w_min_next;
      r_max        <= w_max_next;
      r_inv_cnt    <= w_inv_next;
    end
  end

  // A finished window replaces the held report only if the slot frees up.
  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_rep_valid <= 1'b0;
      r_rep_min   <= '0;
      r_rep_max   <= '0;
      r_rep_inv   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_rep_load) begin
        r_rep_valid <= 1'b1;
        r_rep_min   <= w_min_next;
        r_rep_max   <= w_max_next;
        r_rep_inv   <= w_inv_next;
      end else if (r_rep_valid && mon.reportReady) begin
        r_rep_valid <= 1'b0;
      end
      if (w_win_end && r_rep_valid && !mon.reportReady) begin
        r_overrun <= 1'b1;
      end else if (!mon.monitorEnable) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef DCO_MON_DITHER_COUNT_EN
  logic [CNT_W-1:0] r_dith_cnt;
  logic [CNT_W-1:0] r_rep_dith;
  logic [CNT_W-1:0] w_dith_next;

  assign w_dith_next = r_dith_cnt + (mon.dcoDither ? CNT_W'(1) : CNT_W'(0));

  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_dith_cnt <= '0;
    end else if (w_start || w_abort || w_win_end) begin
      r_dith_cnt <= '0;
    end else if (w_sample) begin
      r_dith_cnt <= w_dith_next;
    end
  end

  always_ff @(posedge referenceClock or negedge resetB) begin
    if (!resetB) begin
      r_rep_dith <= '0;
    end else if (w_rep_load) begin
      r_rep_dith <= w_dith_next;
    end
  end

  assign mon.reportDitherCount = r_rep_dith;
`else
  logic w_unused_dither;
  assign w_unused_dither       = mon.dcoDither;
  assign mon.reportDitherCount = '0;
`endif

  assign mon.currentCode        = r_code;
  assign mon.currentCodeValid   = r_code_valid;
  assign mon.reportValid        = r_rep_valid;
  assign mon.reportMinCode      = r_rep_min;
  assign mon.reportMaxCode      = r_rep_max;
  assign mon.reportInvalidCount = r_rep_inv;
  assign mon.overrun            = r_overrun;

endmodule : dco_code_monitor

// File: tb/tb_dco_code_monitor.sv
// Self-checking bench for dco_code_monitor: directed scenarios plus a random
// soak, all compared against a window-level reference model.
module tb_dco_code_monitor;

  logic clk = 1'b0;
  logic rst_b;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  dco_code_monitor_if u_if ();

  dco_code_monitor u_dut (
    .referenceClock (clk),
    .resetB         (rst_b),
    .mon            (u_if)
  );

  typedef struct {
    int code;
    bit legal;
    bit dith;
  } samp_t;

  samp_t q[$];
  bit    m_obs;
  int    m_len;
  int    m_code, m_cval, m_rvalid, m_rmin, m_rmax, m_rdith, m_rinv, m_ovr;
  int    saved_min;

  function automatic int win_len(input logic [3:0] sel);
    return 1 << ((sel > 4'd10) ? 10 : int'(sel));
  endfunction

  function automatic void ref_decode(input logic [15:0] row, input logic [13:0] col,
                                     output bit legal, output int code);
    int zr, zc;
    logic [15:0] rt;
    logic [13:0] ct;
    zr = 16 - $countones(row);
    zc = 14 - $countones(col);
    rt = 16'hFFFF;
    ct = 14'h3FFF;
    rt = rt << zr;
    ct = ct << zc;
    legal = (row == rt) && (col == ct);
    code  = zr * 15 + zc;
  endfunction

  task automatic model_reset();
    m_obs = 0; m_len = 1; q.delete();
    m_code = 0; m_cval = 0; m_rvalid = 0; m_rmin = 0; m_rmax = 0;
    m_rdith = 0; m_rinv = 0; m_ovr = 0;
  endtask

  // Evaluate one clock edge from the inputs currently applied.
  task automatic model_step();
    bit lg, win_end, accept;
    int cd, mn, mx, nd, ni;
    ref_decode(u_if.dcoRowSelect, u_if.dcoColumnSelect, lg, cd);
    accept  = (m_rvalid != 0) && u_if.reportReady;
    win_end = 0;
    if (lg) m_code = cd;
    m_cval = lg;
    if (!m_obs) begin
      if (u_if.monitorEnable) begin
        m_obs = 1; m_len = win_len(u_if.windowSel); q.delete();
      end
    end else if (!u_if.monitorEnable) begin
      m_obs = 0; q.delete();
    end else begin
      q.push_back('{cd, lg, u_if.dcoDither});
      if (q.size() == m_len) win_end = 1;
    end
    if (win_end) begin
      if (m_rvalid == 0 || accept) begin
        mn = 255; mx = 0; nd = 0; ni = 0;
        foreach (q[i]) begin
          if (q[i].legal) begin
            if (q[i].code < mn) mn = q[i].code;
            if (q[i].code > mx) mx = q[i].code;
          end else ni++;
          if (q[i].dith) nd++;
        end
        m_rvalid = 1; m_rmin = mn; m_rmax = mx; m_rinv = ni;
`ifdef DCO_MON_DITHER_COUNT_EN
        m_rdith = nd;
`else
        m_rdith = 0;
`endif
      end else begin
        m_ovr = 1;
      end
      q.delete();
      m_len = win_len(u_if.windowSel);
    end else if (accept) begin
      m_rvalid = 0;
    end
    if (!u_if.monitorEnable) m_ovr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("currentCode",        32'(u_if.currentCode),        m_code);
    chk("currentCodeValid",   32'(u_if.currentCodeValid),   m_cval);
    chk("reportValid",        32'(u_if.reportValid),        m_rvalid);
    chk("reportMinCode",      32'(u_if.reportMinCode),      m_rmin);
    chk("reportMaxCode",      32'(u_if.reportMaxCode),      m_rmax);
    chk("reportDitherCount",  32'(u_if.reportDitherCount),  m_rdith);
    chk("reportInvalidCount", 32'(u_if.reportInvalidCount), m_rinv);
    chk("overrun",            32'(u_if.overrun),            m_ovr);
  endtask

  task automatic cycle();
    if (rst_b) model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_sel(input logic [15:0] row, input logic [13:0] col);
    u_if.dcoRowSelect    = row;
    u_if.dcoColumnSelect = col;
  endtask

  task automatic set_rand_legal();
    logic [15:0] r;
    logic [13:0] c;
    r = 16'hFFFF;
    c = 14'h3FFF;
    r = r << $urandom_range(0, 16);
    c = c << $urandom_range(0, 14);
    set_sel(r, c);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_dith;
    logic [15:0] rr;
    logic [13:0] cc;
`ifdef DCO_MON_DITHER_COUNT_EN
    exp_dith = 4;
`else
    exp_dith = 0;
`endif
    rst_b = 1'b0;
    u_if.monitorEnable = 1'b0;
    u_if.windowSel     = 4'd0;
    u_if.dcoDither     = 1'b0;
    u_if.reportReady   = 1'b1;
    set_sel(16'hFFFF, 14'h3FFF);
    model_reset();
    cycle();
    cycle();
    chk("reset_cval", 32'(u_if.currentCodeValid), 0);
    rst_b = 1'b1;
    cycle();

    // Held legal selects: code 63, window of 16 identical samples.
    u_if.reportReady = 1'b0;
    u_if.windowSel   = 4'd4;
    set_sel(16'hFFF0, 14'h3FF8);
    u_if.monitorEnable = 1'b1;
    cycle();
    chk("r022_code", 32'(u_if.currentCode), 63);
    for (int i = 0; i < 16; i++) cycle();
    chk("r022_rvalid", 32'(u_if.reportValid), 1);
    chk("r022_min", 32'(u_if.reportMinCode), 63);
    chk("r022_max", 32'(u_if.reportMaxCode), 63);
    chk("r022_inv", 32'(u_if.reportInvalidCount), 0);
    u_if.monitorEnable = 1'b0;
    u_if.reportReady   = 1'b1;
    cycle();
    chk("r022_accept", 32'(u_if.reportValid), 0);

    // Extreme codes alternating over a 4-sample window.
    u_if.reportReady = 1'b0;
    u_if.windowSel   = 4'd2;
    set_sel(16'h0000, 14'h0000);
    u_if.monitorEnable = 1'b1;
    cycle();
    chk("r023_code254", 32'(u_if.currentCode), 254);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) set_sel(16'hFFFF, 14'h3FFF);
      else            set_sel(16'h0000, 14'h0000);
      cycle();
      if (i == 0) chk("r023_code0", 32'(u_if.currentCode), 0);
    end
    chk("r023_min", 32'(u_if.reportMinCode), 0);
    chk("r023_max", 32'(u_if.reportMaxCode), 254);
    u_if.monitorEnable = 1'b0;
    u_if.reportReady   = 1'b1;
    cycle();

    // Three illegal row samples in a 16-sample window.
    u_if.reportReady = 1'b0;
    u_if.windowSel   = 4'd4;
    set_rand_legal();
    u_if.monitorEnable = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) begin
      set_rand_legal();
      if (i == 2 || i == 7 || i == 11) u_if.dcoRowSelect = 16'hFFF5;
      cycle();
      if (i == 2 || i == 7 || i == 11) chk("r024_cval", 32'(u_if.currentCodeValid), 0);
    end
    chk("r024_inv", 32'(u_if.reportInvalidCount), 3);
    u_if.monitorEnable = 1'b0;
    u_if.reportReady   = 1'b1;
    cycle();

    // Two window ends with no acceptance: first report kept, overrun set.
    u_if.reportReady = 1'b0;
    u_if.windowSel   = 4'd1;
    set_sel(16'hFFF0, 14'h3FF8);
    u_if.monitorEnable = 1'b1;
    cycle();
    cycle();
    cycle();
    saved_min = m_rmin;
    chk("r025_first", 32'(u_if.reportMinCode), 63);
    set_sel(16'h0000, 14'h0000);
    cycle();
    cycle();
    chk("r025_overrun", 32'(u_if.overrun), 1);
    chk("r025_keep_min", 32'(u_if.reportMinCode), saved_min);
    chk("r025_keep_max", 32'(u_if.reportMaxCode), 63);
    u_if.monitorEnable = 1'b0;
    cycle();
    chk("r025_ovr_clr", 32'(u_if.overrun), 0);
    chk("r025_pending", 32'(u_if.reportValid), 1);
    u_if.reportReady = 1'b1;
    cycle();
    chk("r025_accept", 32'(u_if.reportValid), 0);

    // Dither toggling every cycle over an 8-sample window.
    u_if.reportReady = 1'b0;
    u_if.windowSel   = 4'd3;
    set_rand_legal();
    u_if.monitorEnable = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      u_if.dcoDither = ~u_if.dcoDither;
      cycle();
    end
    chk("r026_dither", 32'(u_if.reportDitherCount), exp_dith);
    u_if.monitorEnable = 1'b0;
    u_if.reportReady   = 1'b1;
    u_if.dcoDither     = 1'b0;
    cycle();

    // Oversized windowSel clamps to a 1024-sample window.
    u_if.windowSel = 4'd15;
    u_if.monitorEnable = 1'b1;
    cycle();
    for (int i = 0; i < 1024; i++) begin
      set_rand_legal();
      u_if.dcoDither = 1'($urandom);
      cycle();
      if (i == 1022) chk("clamp_early", 32'(u_if.reportValid), 0);
    end
    chk("clamp_rvalid", 32'(u_if.reportValid), 1);
    u_if.monitorEnable = 1'b0;
    cycle();

    // Async reset mid-window; next window sees only post-reset samples.
    u_if.reportReady = 1'b1;
    u_if.windowSel   = 4'd4;
    set_sel(16'h0000, 14'h0000);
    u_if.monitorEnable = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("r027_code_zero", 32'(u_if.currentCode), 0);
    cycle();
    rst_b = 1'b1;
    u_if.reportReady = 1'b0;
    set_sel(16'hFFFF, 14'h3FFF);
    cycle();
    for (int i = 0; i < 16; i++) cycle();
    chk("r027_rvalid", 32'(u_if.reportValid), 1);
    chk("r027_max", 32'(u_if.reportMaxCode), 0);
    chk("r027_min", 32'(u_if.reportMinCode), 0);
    u_if.monitorEnable = 1'b0;
    u_if.reportReady   = 1'b1;
    cycle();

    // Random soak, including empty-legal windows and busy consumers.
    for (int i = 0; i < 2500; i++) begin
      u_if.monitorEnable = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 15) == 0) u_if.windowSel = 4'($urandom_range(0, 4));
      u_if.reportReady = ($urandom_range(0, 3) != 0);
      u_if.dcoDither   = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rr = 16'($urandom);
        cc = 14'($urandom);
        set_sel(rr, cc);
      end else begin
        set_rand_legal();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_dco_code_monitor
